seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed hex digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000, clocks per digit slot, legal value >= 2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  single-cycle strobe that captures value and dp_in.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; value[3:0] is digit 0 (least significant).
REQ-007 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 seg  output  7  segments, active-low; bit0 = a (top), bit1 = b, bit2 = c, bit3 = d, bit4 = e, bit5 = f, bit6 = g (middle).
REQ-009 dp  output  1  decimal point of the active digit, active-low.
REQ-010 an  output  NUM_DIGITS  digit enables, active-low, at most one low at a time.
REQ-011 frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The prescaler counts 0..DIV-1 and wraps to 0; the cycle in which it wraps is the slot tick.
REQ-013 Digit index idx advances on each slot tick, and wraps from NUM_DIGITS-1 to 0.
REQ-014 A frame is NUM_DIGITS*DIV clocks; frame is high for exactly the one clock in which idx wraps from NUM_DIGITS-1 to 0.
REQ-015 On load=1, value and dp_in go into a pending register and a pending flag is set.
REQ-016 If load=1 again before the frame boundary, the pending register takes the newest data (last wins).
REQ-017 At the frame boundary, if the pending flag is set, the pending data transfers to the shadow register and the flag clears.
REQ-018 If load=1 in the boundary cycle itself, the data presented in that cycle goes to the shadow register and the flag stays clear.
REQ-019 Display outputs read only the shadow register, so no mid-frame tearing.
REQ-020 seg, dp and an are registered and lag the counter/index state by one clock.
REQ-021 Dead time: in the first clock of each slot (prescaler = 0), an = all 1s, seg = 7'h7F and dp = 1.
REQ-022 For the remaining DIV-1 clocks of slot k: an[k] = 0, all other an bits = 1, seg = decode(nibble k), dp = ~dp bit k.
REQ-023 Decode, as hex seg values: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E; blank = 7F.

Reset
REQ-024 While rst = 1: prescaler = 0, idx = 0, shadow = 0, pending data = 0, pending flag = 0.
REQ-025 While rst = 1: an = all 1s, seg = 7'h7F, dp = 1, frame = 0.
REQ-026 rst has priority over load.
REQ-027 Asserting rst mid-frame discards any pending load.
REQ-028 After rst deasserts, scanning restarts at slot 0, beginning with a dead-time clock.

Configuration
REQ-029 Macro SEG7_LZB_EN defined: leading-zero blanking is compiled in.
REQ-030 With SEG7_LZB_EN, every digit above the most-significant nonzero shadow nibble shows seg = 7F.
REQ-031 With SEG7_LZB_EN, an still scans normally; digit 0 is never blanked; dp is unaffected by blanking.
REQ-032 Macro SEG7_LZB_EN not defined: every digit shows its decoded nibble, and no blanking logic is present.

Verification (NUM_DIGITS = 4, DIV = 4)
REQ-033 Reset: hold rst high 3 clocks -> an = 4'b1111, seg = 7F, dp = 1, frame = 0 throughout; first frame pulse 16 clocks after release.
REQ-034 Load value = 16'h12AF, dp_in = 4'b0100 -> from the next frame, each slot shows 1 clock of an = 1111 followed by 3 clocks of:
- an = 1110, seg = 0E
- an = 1101, seg = 08
- an = 1011, seg = 24, dp = 0
- an = 0111, seg = 79
REQ-035 Mid-frame loads of 16'h1111 then 16'h2222 -> current frame unchanged; next frame shows all digits = 24; frame period stays 16 clocks.
REQ-036 Load value = 16'h0050 -> with SEG7_LZB_EN, digits 3..0 show 7F, 7F, 12, 40; without it, 40, 40, 12, 40.
REQ-037 Load value = 16'h0000 with SEG7_LZB_EN -> digit 0 shows 40; digits 1..3 show 7F with their an still pulsing low.
REQ-038 Assert rst during slot 2 with a load pending -> reset values on the next clock; after release, the pending data never appears and the display shows 0s.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex 7-segment scanner with frame-synchronous double-buffered display data.
// Define SEG7_LZB_EN to compile in leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val, pend_val;
    logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
    logic                    pend, tick, wrap;
    logic [3:0]              nib;
    logic [6:0]              seg_n;

    assign tick  = cnt == CW'(DIV - 1);
    assign wrap  = tick && idx == IW'(NUM_DIGITS - 1);
    assign frame = wrap && !rst;
    assign nib   = shadow_val[{idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic z;
        lz = '0;
        z = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            z = z && shadow_val[4*k +: 4] == 4'd0;
            lz[k] = z;
        end
    end
    assign seg_n = lz[idx] ? 7'h7F : HEX[nib];
`else
    assign seg_n = HEX[nib];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
            // a load in the boundary cycle bypasses the pending stage
            if (wrap) begin
                shadow_val <= load ? value : pend ? pend_val : shadow_val;
                shadow_dp  <= load ? dp_in : pend ? pend_dp : shadow_dp;
                pend       <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt == '0) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= seg_n;
            dp  <= ~shadow_dp[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver at NUM_DIGITS=4, DIV=4.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;
    int          n_checks = 0;
    int          n_err = 0;
    logic [11:0] sb [$];

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

    seg7_scan_driver #(.NUM_DIGITS(4), .DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // 16 display cycles of one frame, packed {an, seg, dp}
    function automatic logic [11:0] exp_word(input int j, input logic [15:0] v, input logic [3:0] d);
        int s = j / 4;
        logic [6:0] sg;
`ifdef SEG7_LZB_EN
        logic [15:0] hi;
`endif
        if (j % 4 == 0)
            return {4'hF, 7'h7F, 1'b1};
        sg = HEX[v[4*s +: 4]];
`ifdef SEG7_LZB_EN
        hi = v >> (4 * s);
        if (s > 0 && hi == 16'd0)
            sg = 7'h7F;
`endif
        return {~(4'b0001 << s), sg, ~d[s]};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
        for (int j = 0; j < 16; j++)
            sb.push_back(exp_word(j, v, d));
    endtask

    // entered at the negedge just after a frame pulse; leaves at the same point of the next frame
    task automatic frame_step(input logic [15:0] v1, input logic [3:0] d1, input int at1,
                              input logic [15:0] v2, input logic [3:0] d2, input int at2);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (sb.size() == 0)
                check("sb_underflow", 1, 0);
            else
                check("disp", {an, seg, dp}, sb.pop_front());
            check("frame", frame, i == 15);
            load  = (i == at1) || (i == at2);
            value = i == at2 ? v2 : v1;
            dp_in = i == at2 ? d2 : d1;
        end
    endtask

    task automatic wait_frame();
        int n = 1;
        while (!frame && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_lat", n, 16);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {an, seg, dp, frame}, RST_OUT);
        end
        rst = 1'b0;
        wait_frame();
        @(negedge clk);
        push_frame(16'h0000, 4'b0000);
        frame_step(16'h12AF, 4'b0100, 5, 16'h0, 4'h0, -1);
        push_frame(16'h12AF, 4'b0100);
        frame_step(16'h1111, 4'b0001, 3, 16'h2222, 4'b1000, 9);
        push_frame(16'h2222, 4'b1000);
        frame_step(16'h0050, 4'b0000, 15, 16'h0, 4'h0, -1);
        push_frame(16'h0050, 4'b0000);
        frame_step(16'h0000, 4'b0010, 15, 16'h0, 4'h0, -1);
        push_frame(16'h0000, 4'b0010);
        frame_step(16'h0, 4'h0, -1, 16'h0, 4'h0, -1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            load  = i == 2;
            value = 16'hBEEF;
            dp_in = 4'hF;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {an, seg, dp, frame}, RST_OUT);
        @(negedge clk);
        check("rst_mid2", {an, seg, dp, frame}, RST_OUT);
        rst = 1'b0;
        wait_frame();
        @(negedge clk);
        push_frame(16'h0000, 4'b0000);
        frame_step(16'h0, 4'h0, -1, 16'h0, 4'h0, -1);
        push_frame(16'h0000, 4'b0000);
        frame_step(16'h0, 4'h0, -1, 16'h0, 4'h0, -1);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
